// File: rtl/apu_pkg.sv
// Shared APU definitions: register file geometry, address-byte marker and
// the loader's parser states.
package apu_pkg;

   localparam int APU_REG_COUNT = 32;
   localparam int APU_ADDR_W    = 5;
   localparam int APU_GROUP_W   = 3;

   // Bits 7:5 of an address byte; the low five bits carry the register index.
   localparam logic [2:0] ADDR_MARK = 3'b100;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_DATA = 1'b1
   } loader_state_e;

   // True when a byte received in IDLE opens a write packet.
   function automatic logic is_addr_byte(input logic [7:0] b);
      return b[7:5] == ADDR_MARK;
   endfunction

endpackage

// File: rtl/apu_reg_loader_if.sv
// Byte stream from the host UART receiver into the register loader.
interface apu_reg_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/apu_reg_file.sv
// 32 x 8 APU register file with a single synchronous write port, a flattened
// read bus, and a per-group toggle so channels can spot fresh writes.
module apu_reg_file
   import apu_pkg::*;
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                we,
   input  logic [APU_ADDR_W-1:0]               waddr,
   input  logic [7:0]                          wdata,
   output logic [APU_REG_COUNT*8-1:0]          apu_reg,
   output logic                                wr_strobe,
   output logic [APU_ADDR_W-1:0]               wr_addr,
   output logic [(1<<APU_GROUP_W)-1:0]         reg_change
);

   logic [APU_REG_COUNT-1:0][7:0] regs;
   logic [APU_GROUP_W-1:0]        grp;

   // Four consecutive registers form one channel group.
   assign grp     = waddr[APU_ADDR_W-1:APU_ADDR_W-APU_GROUP_W];
   assign apu_reg = regs;

   // Commit a write; an unchanged value still strobes and toggles its group.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs       <= '0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         reg_change <= '0;
      end else begin
         wr_strobe <= we;
         if (we) begin
            regs[waddr]     <= wdata;
            wr_addr         <= waddr;
            reg_change[grp] <= ~reg_change[grp];
         end
      end
   end

endmodule

// File: rtl/apu_reg_loader.sv
// Parses address/data byte pairs from the UART into APU register writes.
// A packet left hanging for TIMEOUT_CYCLES is dropped and counted as an error.
module apu_reg_loader
   import apu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 895
) (
   input  logic                        clk,
   input  logic                        reset,
   apu_reg_loader_if.slave             rx,
   output logic [APU_REG_COUNT*8-1:0]  apu_reg,
   output logic                        wr_strobe,
   output logic [APU_ADDR_W-1:0]       wr_addr,
   output logic [7:0]                  reg_change,
   output logic                        busy,
   output logic [7:0]                  err_count
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   loader_state_e          state, state_nxt;
   logic [APU_ADDR_W-1:0]  addr;
   logic [TCNT_W-1:0]      tcnt;
   logic                   addr_ld, tcnt_inc, err_inc, we;

   // State, latched address, timeout counter and saturating error count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         tcnt      <= '0;
         err_count <= '0;
      end else begin
         state <= state_nxt;
         if (addr_ld) begin
            addr <= rx.rx_data[APU_ADDR_W-1:0];
            tcnt <= '0;
         end else if (tcnt_inc) begin
            tcnt <= tcnt + 1'b1;
         end
         if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   // Packet parser: content is only inspected in IDLE; a received byte in
   // WAIT_DATA always completes the packet, even on the timeout cycle.
   always_comb begin
      state_nxt = state;
      addr_ld   = 1'b0;
      tcnt_inc  = 1'b0;
      err_inc   = 1'b0;
      we        = 1'b0;
      case (state)
         IDLE: begin
            if (rx.rx_valid) begin
               if (is_addr_byte(rx.rx_data)) begin
                  addr_ld   = 1'b1;
                  state_nxt = WAIT_DATA;
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         WAIT_DATA: begin
            if (rx.rx_valid) begin
               we        = 1'b1;
               state_nxt = IDLE;
            end else if (tcnt == TO_LAST) begin
               err_inc   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tcnt_inc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == WAIT_DATA);

   apu_reg_file u_reg_file (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .waddr      (addr),
      .wdata      (rx.rx_data),
      .apu_reg    (apu_reg),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .reg_change (reg_change)
   );

endmodule

// File: tb/tb_apu_reg_loader.sv
// Bench for apu_reg_loader: directed packets followed by random byte traffic.
// A packet-level model predicts each edge; writes go through a scoreboard
// queue that the monitor drains whenever wr_strobe appears.
module tb_apu_reg_loader;
   localparam int TO = 895;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [255:0] apu_reg;
   logic         wr_strobe, busy;
   logic [4:0]   wr_addr;
   logic [7:0]   reg_change, err_count;

   apu_reg_loader_if rx_if ();

   apu_reg_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx_if),
      .apu_reg    (apu_reg),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .reg_change (reg_change),
      .busy       (busy),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Reference model state (packet-level view, not the RTL's counters).
   logic [31:0][7:0] m_regs = '0;
   logic [7:0]       m_chg = '0;
   logic [4:0]       m_last = '0;
   int               m_err = 0;
   bit               m_pending = 0;
   logic [4:0]       m_paddr = '0;
   int               m_waited = 0;
   bit               m_strobe = 0;
   logic [20:0]      sb_q[$];   // {addr, data, reg_change after write}

   int  total = 0, bad = 0;
   int  n_strobes = 0;
   bit  chk_en = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Drive one byte (or an idle cycle), let the edge sample it, then advance
   // the model by that same edge.
   task automatic step(input logic v, input logic [7:0] d);
      rx_if.rx_valid = v;
      rx_if.rx_data  = d;
      @(posedge clk);
      m_strobe = 0;
      if (reset) begin
         m_regs = '0; m_chg = '0; m_last = '0; m_err = 0;
         m_pending = 0; m_paddr = '0; m_waited = 0;
         sb_q.delete();
      end else if (m_pending) begin
         if (v) begin
            m_regs[m_paddr] = d;
            m_chg[m_paddr / 4] = ~m_chg[m_paddr / 4];
            m_last = m_paddr;
            m_strobe = 1;
            m_pending = 0;
            sb_q.push_back({m_paddr, d, m_chg});
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               m_pending = 0;
               if (m_err < 255) m_err++;
            end
         end
      end else if (v) begin
         if (d[7] == 1'b1 && d[6:5] == 2'b00) begin
            m_pending = 1; m_paddr = d[4:0]; m_waited = 0;
         end else if (m_err < 255) begin
            m_err++;
         end
      end
      #1;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   // Monitor: every cycle against the model, and pop the scoreboard per strobe.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_strobe", 256'(wr_strobe), 256'(m_strobe));
         chk("busy", 256'(busy), 256'(m_pending));
         chk("err_count", 256'(err_count), 256'(m_err));
         chk("apu_reg", apu_reg, m_regs);
         chk("reg_change", 256'(reg_change), 256'(m_chg));
         chk("wr_addr", 256'(wr_addr), 256'(m_last));
         if (wr_strobe) begin
            n_strobes++;
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write: addr %0d with empty scoreboard", wr_addr);
            end else begin
               logic [20:0] e;
               e = sb_q.pop_front();
               chk("sb_addr", 256'(wr_addr), 256'(e[20:16]));
               chk("sb_data", 256'(apu_reg[wr_addr*8 +: 8]), 256'(e[15:8]));
               chk("sb_change", 256'(reg_change), 256'(e[7:0]));
            end
         end
      end
   end

   initial begin
      logic [7:0] r;
      int s0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
      reset = 1'b1;
      idle(2);
      chk_en = 1;
      reset = 1'b0;
      idle(1);

      // Basic write to reg 0.
      step(1, 8'h80); step(1, 8'h3F); idle(2);
      chk("reg0", 256'(apu_reg[7:0]), 256'h3F);
      chk("chg_reg0", 256'(reg_change), 256'h01);

      // Same value twice to reg 31: two strobes, group 7 toggles back.
      s0 = n_strobes;
      step(1, 8'h9F); step(1, 8'hA5); idle(1);
      chk("chg7_set", 256'(reg_change[7]), 256'h1);
      step(1, 8'h9F); step(1, 8'hA5); idle(1);
      chk("chg7_clr", 256'(reg_change[7]), 256'h0);
      chk("two_strobes", 256'(n_strobes - s0), 256'd2);

      // Invalid bytes in IDLE.
      step(1, 8'h12); step(1, 8'hE3); idle(1);
      chk("err_two", 256'(err_count), 256'd2);

      // Timeout on reg 3, then a real write.
      step(1, 8'h83); idle(TO - 1);
      chk("busy_before_to", 256'(busy), 256'd1);
      idle(1);
      chk("busy_after_to", 256'(busy), 256'd0);
      chk("err_after_to", 256'(err_count), 256'd3);
      step(1, 8'h83); step(1, 8'h81); idle(1);
      chk("reg3", 256'(apu_reg[31:24]), 256'h81);

      // Data byte that looks like an address.
      step(1, 8'h85); step(1, 8'h85); idle(1);
      chk("reg5", 256'(apu_reg[47:40]), 256'h85);
      chk("idle_after_85", 256'(busy), 256'd0);

      // Data arriving on the exact timeout cycle still commits.
      step(1, 8'h86); idle(TO - 1); step(1, 8'h6C); idle(1);
      chk("reg6_edge", 256'(apu_reg[55:48]), 256'h6C);

      // Saturation.
      for (int i = 0; i < 300; i++) step(1, 8'h40);
      chk("err_sat", 256'(err_count), 256'd255);

      // Reset together with the data byte.
      step(1, 8'h82);
      reset = 1'b1; step(1, 8'h55); reset = 1'b0;
      chk("reset_reg", apu_reg, 256'd0);
      chk("reset_busy", 256'(busy), 256'd0);
      chk("reset_err", 256'(err_count), 256'd0);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 3) != 0) r[7:5] = 3'b100;
         step(1, r);
         case ($urandom_range(0, 40))
            0:       idle(TO - 1 + $urandom_range(0, 2));
            1, 2, 3: idle($urandom_range(1, 4));
            default: ;
         endcase
      end
      idle(3);
      chk("sb_empty", 256'(sb_q.size()), 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
